// File: rtl/inst_queue_pkg.sv
// Shared definitions for the fetch-to-decode instruction path: fetch package field positions,
// queue entry layout and the sequential PC step between the two instructions of a package.
package inst_queue_pkg;

  // Fetch package field positions (128-bit package)
  localparam int unsigned PKG_PC_HI = 127;
  localparam int unsigned PKG_PC_LO = 96;
  localparam int unsigned PKG_I1_HI = 95;
  localparam int unsigned PKG_I1_LO = 64;
  localparam int unsigned PKG_I2_HI = 63;
  localparam int unsigned PKG_I2_LO = 32;
  localparam int unsigned PKG_V1    = 31;
  localparam int unsigned PKG_V2    = 30;
  localparam int unsigned PKG_BR1   = 29;
  localparam int unsigned PKG_PT1   = 28;
  localparam int unsigned PKG_BR2   = 27;
  localparam int unsigned PKG_PT2   = 26;

  localparam int unsigned PKG_W   = 128;
  localparam int unsigned ENTRY_W = 66;

  // Byte distance from inst1 to inst2 within one package
  localparam logic [31:0] PC_INC = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        br;
    logic        pt;
  } entry_t;

  function automatic entry_t make_entry(input logic [31:0] pc, input logic [31:0] inst,
                                        input logic br, input logic pt);
    entry_t e;
    e.pc   = pc;
    e.inst = inst;
    e.br   = br;
    e.pt   = pt;
    return e;
  endfunction

endpackage

// File: rtl/inst_queue.sv
// Decoupling instruction queue between fetch and dual-issue decode. Splits each accepted fetch
// package into up to two entries, buffers them in a circular register array and presents the
// two oldest entries to decode. Flushed on a resolved branch redirect.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              branch_flag_i,
  input  logic              package_valid_i,
  input  logic [PKG_W-1:0]  inst_package_i,
  output logic              stall_o,
  input  logic              id_stall_i,
  output logic              out0_valid_o,
  output logic              out1_valid_o,
  output logic [31:0]       out0_pc_o,
  output logic [31:0]       out1_pc_o,
  output logic [31:0]       out0_inst_o,
  output logic [31:0]       out1_inst_o,
  output logic              out0_br_o,
  output logic              out1_br_o,
  output logic              out0_pt_o,
  output logic              out1_pt_o
);

  // Register array rather than SRAM: decode needs two read ports every cycle.
  entry_t        mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;

  logic [AW-1:0] rd_ptr1, wr_ptr1;
  logic          v1, v2;
  entry_t        e1, e2;
  logic          accept;
  logic          wr_en0, wr_en1;
  entry_t        wr_data0, wr_data1;
  logic [1:0]    push, pop;
  entry_t        slot0, slot1;

  logic unused_pkg_bits;
  assign unused_pkg_bits = ^inst_package_i[PKG_PT2-1:0];

  assign rd_ptr1 = rd_ptr_q + AW'(1);
  assign wr_ptr1 = wr_ptr_q + AW'(1);

  assign v1 = inst_package_i[PKG_V1];
  assign v2 = inst_package_i[PKG_V2];
  assign e1 = make_entry(inst_package_i[PKG_PC_HI:PKG_PC_LO],
                         inst_package_i[PKG_I1_HI:PKG_I1_LO],
                         inst_package_i[PKG_BR1], inst_package_i[PKG_PT1]);
  assign e2 = make_entry(inst_package_i[PKG_PC_HI:PKG_PC_LO] + PC_INC,
                         inst_package_i[PKG_I2_HI:PKG_I2_LO],
                         inst_package_i[PKG_BR2], inst_package_i[PKG_PT2]);

  // Stall from registered count only: leaves room for a 2-entry push whatever decode pops.
  assign stall_o = (count_q > (AW+1)'(DEPTH - 2));
  assign accept  = package_valid_i && !stall_o && !branch_flag_i;

  // Pack the valid instructions of an accepted package into consecutive write slots
  always_comb begin
    wr_en0   = 1'b0;
    wr_en1   = 1'b0;
    wr_data0 = e1;
    wr_data1 = e2;
    if (accept) begin
      if (v1 && v2) begin
        wr_en0 = 1'b1;
        wr_en1 = 1'b1;
      end else if (v1) begin
        wr_en0 = 1'b1;
      end else if (v2) begin
        wr_en0   = 1'b1;
        wr_data0 = e2;
      end
    end
  end

  assign push = {1'b0, wr_en0} + {1'b0, wr_en1};

  // Issue slots are combinational reads of registered state
  assign slot0        = mem_q[rd_ptr_q];
  assign slot1        = mem_q[rd_ptr1];
  assign out0_valid_o = (count_q >= (AW+1)'(1));
  assign out1_valid_o = (count_q >= (AW+1)'(2));
  assign out0_pc_o    = slot0.pc;
  assign out0_inst_o  = slot0.inst;
  assign out0_br_o    = slot0.br;
  assign out0_pt_o    = slot0.pt;
  assign out1_pc_o    = slot1.pc;
  assign out1_inst_o  = slot1.inst;
  assign out1_br_o    = slot1.br;
  assign out1_pt_o    = slot1.pt;

  // Next pointers and occupancy; flush wins over push and pop
  always_comb begin
    pop      = 2'd0;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (!id_stall_i) begin
      pop = {1'b0, out0_valid_o} + {1'b0, out1_valid_o};
    end
    if (branch_flag_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + AW'(pop);
      wr_ptr_d = wr_ptr_q + AW'(push);
      count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // Pointer and count registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage, not reset
  always_ff @(posedge clk) begin
    if (wr_en0) mem_q[wr_ptr_q] <= wr_data0;
    if (wr_en1) mem_q[wr_ptr1]  <= wr_data1;
  end

endmodule

// File: tb/tb_inst_queue.sv
// Bench for inst_queue: directed scenarios followed by random traffic, each cycle compared
// against a queue-based reference model of the instruction stream.
module tb_inst_queue;

  localparam int unsigned DEPTH = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         branch_flag_i;
  logic         package_valid_i;
  logic [127:0] inst_package_i;
  logic         stall_o;
  logic         id_stall_i;
  logic         out0_valid_o, out1_valid_o;
  logic [31:0]  out0_pc_o, out1_pc_o, out0_inst_o, out1_inst_o;
  logic         out0_br_o, out1_br_o, out0_pt_o, out1_pt_o;

  int checks = 0;
  int errors = 0;

  // Reference model: entries {pc, inst, br, pt}, oldest at index 0
  logic [65:0] mq[$];

  inst_queue #(.DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .branch_flag_i   (branch_flag_i),
    .package_valid_i (package_valid_i),
    .inst_package_i  (inst_package_i),
    .stall_o         (stall_o),
    .id_stall_i      (id_stall_i),
    .out0_valid_o    (out0_valid_o),
    .out1_valid_o    (out1_valid_o),
    .out0_pc_o       (out0_pc_o),
    .out1_pc_o       (out1_pc_o),
    .out0_inst_o     (out0_inst_o),
    .out1_inst_o     (out1_inst_o),
    .out0_br_o       (out0_br_o),
    .out1_br_o       (out1_br_o),
    .out0_pt_o       (out0_pt_o),
    .out1_pt_o       (out1_pt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mk(input logic [31:0] pc, input logic [31:0] i1,
                                      input logic [31:0] i2, input logic v1, input logic v2,
                                      input logic br1, input logic pt1, input logic br2,
                                      input logic pt2);
    logic [25:0] junk;
    junk = 26'($urandom);
    return {pc, i1, i2, v1, v2, br1, pt1, br2, pt2, junk};
  endfunction

  // One cycle: drive inputs, compare outputs against the model, clock, advance the model
  task automatic step(input logic r, input logic bf, input logic pv, input logic ids,
                      input logic [127:0] pk);
    logic stall_e;
    int   n;
    int   pop;
    rst             = r;
    branch_flag_i   = bf;
    package_valid_i = pv;
    id_stall_i      = ids;
    inst_package_i  = pk;
    #1;
    n       = mq.size();
    stall_e = (n > int'(DEPTH) - 2);
    chk("stall", 66'(stall_o), 66'(stall_e));
    chk("valid0", 66'(out0_valid_o), 66'(n >= 1));
    chk("valid1", 66'(out1_valid_o), 66'(n >= 2));
    chk("count", 66'(dut.count_q), 66'(n));
    if (n >= 1) chk("slot0", {out0_pc_o, out0_inst_o, out0_br_o, out0_pt_o}, mq[0]);
    if (n >= 2) chk("slot1", {out1_pc_o, out1_inst_o, out1_br_o, out1_pt_o}, mq[1]);
    @(posedge clk);
    if (r || bf) begin
      mq.delete();
    end else begin
      pop = ids ? 0 : ((n >= 2) ? 2 : n);
      repeat (pop) void'(mq.pop_front());
      if (pv && !stall_e) begin
        if (pk[31]) mq.push_back({pk[127:96], pk[95:64], pk[29], pk[28]});
        if (pk[30]) mq.push_back({pk[127:96] + 32'd4, pk[63:32], pk[27], pk[26]});
      end
    end
    @(negedge clk);
  endtask

  logic [31:0]  next_pc;
  logic [127:0] held;

  initial begin
    rst = 1'b1;
    branch_flag_i = 1'b0;
    package_valid_i = 1'b0;
    id_stall_i = 1'b1;
    inst_package_i = '0;
    @(negedge clk);
    @(negedge clk);

    // First package lands in both slots one cycle later; reset state checked here
    step(0, 0, 1, 1, mk(32'h8000_0000, 32'h1111_0001, 32'h2222_0002, 1, 1, 0, 0, 0, 0));
    step(0, 0, 0, 1, '0);
    chk("first_pc1", 66'(out1_pc_o), 66'(32'h8000_0004));

    // Fill to DEPTH with decode stalled; the next package is held until room opens
    step(0, 0, 1, 1, mk(32'h8000_0008, 32'hA, 32'hB, 1, 1, 0, 0, 0, 0));
    step(0, 0, 1, 1, mk(32'h8000_0010, 32'hC, 32'hD, 1, 1, 0, 0, 0, 0));
    step(0, 0, 1, 1, mk(32'h8000_0018, 32'hE, 32'hF, 1, 1, 0, 0, 0, 0));
    held = mk(32'h8000_0020, 32'h10, 32'h11, 1, 1, 0, 0, 0, 0);
    step(0, 0, 1, 1, held);
    chk("full_stall", 66'(stall_o), 66'(1));
    step(0, 0, 1, 1, held);
    step(0, 0, 1, 0, held);
    step(0, 0, 1, 1, held);
    step(0, 0, 0, 1, '0);

    // Mid-operation reset behaves like a flush
    step(1, 0, 1, 1, mk(32'h9000_0000, 32'h1, 32'h2, 1, 1, 0, 0, 0, 0));
    step(0, 0, 0, 1, '0);

    // Single entries carrying branch/prediction flags, including PC wrap on inst2
    step(0, 0, 1, 1, mk(32'hFFFF_FFF8, 32'h33, 32'h44, 1, 0, 1, 1, 0, 0));
    step(0, 0, 1, 1, mk(32'hFFFF_FFFC, 32'h55, 32'h66, 0, 1, 0, 0, 1, 0));
    step(0, 0, 1, 1, mk(32'h0000_0100, 32'h77, 32'h88, 0, 0, 1, 1, 1, 1));
    step(0, 0, 0, 1, '0);
    step(0, 1, 0, 1, '0);
    step(0, 0, 1, 1, mk(32'h0000_0200, 32'h99, 32'hAA, 1, 0, 1, 1, 0, 0));
    step(0, 0, 0, 1, '0);
    chk("single_br", 66'({out0_br_o, out0_pt_o, out1_valid_o}), 66'(3'b110));

    // Flush at count 5 drops the same-cycle package
    step(0, 1, 0, 1, '0);
    step(0, 0, 1, 1, mk(32'h0000_1000, 32'h1, 32'h2, 1, 1, 0, 0, 0, 0));
    step(0, 0, 1, 1, mk(32'h0000_1008, 32'h3, 32'h4, 1, 1, 0, 0, 0, 0));
    step(0, 0, 1, 1, mk(32'h0000_1010, 32'h5, 32'h6, 1, 0, 0, 0, 0, 0));
    step(0, 1, 1, 1, mk(32'h0000_1018, 32'h7, 32'h8, 1, 1, 0, 0, 0, 0));
    step(0, 0, 0, 1, '0);

    // Count 1 with a pop and a 2-entry push in the same cycle
    step(0, 0, 1, 1, mk(32'h0000_2000, 32'h21, 32'h22, 1, 0, 0, 0, 0, 0));
    step(0, 0, 1, 0, mk(32'h0000_3000, 32'h31, 32'h32, 1, 1, 0, 0, 0, 0));
    step(0, 0, 0, 1, '0);
    chk("cnt1_order", 66'(out0_pc_o), 66'(32'h0000_3000));

    // Streaming: issued PCs must form one unbroken sequence across pointer wraps
    step(0, 1, 0, 0, '0);
    next_pc = 32'h0000_4000;
    for (int i = 0; i < 22; i++) begin
      if (i < 20) begin
        step(0, 0, 1, 0, mk(32'h0000_4000 + 32'(i * 8), 32'(i), 32'(i + 100), 1, 1, 0, 0, 0, 0));
      end else begin
        step(0, 0, 0, 0, '0);
      end
      if (out0_valid_o) chk("seq0", 66'(out0_pc_o), 66'(next_pc));
      if (out1_valid_o) chk("seq1", 66'(out1_pc_o), 66'(next_pc + 32'd4));
      next_pc = next_pc + 32'd4 * (32'(out0_valid_o) + 32'(out1_valid_o));
    end
    chk("stream_total", 66'(next_pc), 66'(32'h0000_4000 + 32'd160));

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 64) == 0, ($urandom % 16) == 0, ($urandom % 4) != 0,
           ($urandom % 3) == 0,
           mk($urandom, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom), 1'($urandom)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
